// File: rtl/rom_port_arbiter.sv
// Four-port arbiter sharing one variable-latency ROM read port, with a one-entry
// last-address cache per port. Define ROM_ARB_RR_EN for round-robin; default is fixed priority.
module rom_port_arbiter #(
  parameter int AW = 16
) (
  input  logic            clk_49m,
  input  logic            reset,
  input  logic            inval,
  input  logic [3:0]      req,
  input  logic [4*AW-1:0] addr,
  output logic [3:0]      ack,
  output logic [31:0]     dout,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  input  logic            mem_rdy,
  input  logic [7:0]      mem_din,
  output logic            busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    win;
  logic [1:0]    pick;
  logic [AW-1:0] pick_addr;
  logic          hit;
  logic [AW-1:0] tag [4];
  logic [3:0]    valid;

`ifdef ROM_ARB_RR_EN
  logic [1:0] ptr;
  logic [1:0] cand;

  // Scan from farthest to nearest so the port just after ptr wins last.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    pick = ptr;
    cand = ptr;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) pick = cand;
    end
  end
`else
  always_comb begin
    pick = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) pick = 2'(k);
    end
  end
`endif

  assign pick_addr = addr[pick*AW +: AW];
  assign hit       = valid[pick] && !inval && (tag[pick] == pick_addr);
  assign busy      = (state != ST_IDLE);

  // dout doubles as the cache data: it only changes together with tag.
  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      win      <= 2'd0;
      ack      <= '0;
      dout     <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      valid    <= '0;
      // NOTE: the tag array is only four registers, so it is cleared in reset rather than inferred as RAM.
      for (int i = 0; i < 4; i++) tag[i] <= '0;
`ifdef ROM_ARB_RR_EN
      ptr      <= 2'd3;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values, whatever the statement order.
      ack <= '0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            win <= pick;
`ifdef ROM_ARB_RR_EN
            ptr <= pick;
`endif
            if (hit) begin
              ack   <= 4'b0001 << pick;
              state <= ST_ACK;
            end else begin
              mem_addr <= pick_addr;
              mem_req  <= 1'b1;
              state    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem_rdy) begin
            mem_req           <= 1'b0;
            dout[win*8 +: 8]  <= mem_din;
            tag[win]          <= mem_addr;
            valid[win]        <= 1'b1;
            ack               <= 4'b0001 << win;
            state             <= ST_ACK;
          end
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      // Download in progress wins over any fill completing this cycle.
      if (inval) valid <= '0;
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed scenarios plus randomized waves
// checked against a cache/arbitration reference model.
module tb_rom_port_arbiter;
  localparam int AW = 16;

  logic            clk_49m = 1'b0;
  logic            reset;
  logic            inval;
  logic [3:0]      req;
  logic [4*AW-1:0] addr;
  logic [3:0]      ack;
  logic [31:0]     dout;
  logic            mem_req;
  logic [AW-1:0]   mem_addr;
  logic            mem_rdy;
  logic [7:0]      mem_din;
  logic            busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int            g_port[$];
  logic [7:0]    g_data[$];
  logic [AW-1:0] g_maddr[$];

  bit            m_valid [4];
  logic [AW-1:0] m_tag   [4];
  int            m_ptr;

  always #10 clk_49m = ~clk_49m;

  rom_port_arbiter #(.AW(AW)) dut (
    .clk_49m (clk_49m),
    .reset   (reset),
    .inval   (inval),
    .req     (req),
    .addr    (addr),
    .ack     (ack),
    .dout    (dout),
    .mem_req (mem_req),
    .mem_addr(mem_addr),
    .mem_rdy (mem_rdy),
    .mem_din (mem_din),
    .busy    (busy)
  );

  // ROM contents; 0x1234 maps to 0xA5.
  function automatic logic [7:0] rom(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h83;
  endfunction

  function automatic int arbitrate(input logic [3:0] pend, input int last);
`ifdef ROM_ARB_RR_EN
    for (int i = 1; i <= 4; i++) begin
      if (pend[(last + i) % 4]) return (last + i) % 4;
    end
`else
    for (int p = 0; p < 4; p++) begin
      if (pend[p]) return p;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 4; p++) begin
      m_valid[p] = 1'b0;
      m_tag[p]   = '0;
    end
    m_ptr = 3;
  endtask

  task automatic do_reset();
    @(negedge clk_49m);
    reset = 1'b1;
    req = '0; mem_rdy = 1'b0; inval = 1'b0;
    @(negedge clk_49m);
    reset = 1'b0;
    model_reset();
  endtask

  // Drives the memory side and records acks until all requests are served.
  task automatic run_until_done(input int budget, input int max_delay, output bit timed_out);
    int delay_left;
    delay_left = -1;
    timed_out  = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_49m);
      mem_rdy = 1'b0;
      if (ack != 4'b0000) begin
        for (int p = 0; p < 4; p++) begin
          if (ack[p]) begin
            g_port.push_back(p);
            g_data.push_back(dout[p*8 +: 8]);
          end
        end
        req = req & ~ack;
      end
      if (mem_req) begin
        if (delay_left < 0) begin
          g_maddr.push_back(mem_addr);
          delay_left = $urandom_range(0, max_delay);
        end
        if (delay_left == 0) begin
          mem_rdy    = 1'b1;
          mem_din    = rom(mem_addr);
          delay_left = -1;
        end else begin
          delay_left--;
        end
      end
      if (req == 4'b0000 && !busy && !mem_req) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; inval = 1'b0; req = '0; addr = '0; mem_rdy = 1'b0; mem_din = '0;
    repeat (2) @(negedge clk_49m);
    reset = 1'b0;
    model_reset();
    @(negedge clk_49m);
    total_cnt++; if (ack !== 4'b0000) $display("FAIL reset_ack: got %b expected 0000", ack); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b expected 0", mem_req); else pass_cnt++;
    total_cnt++; if (mem_addr !== 16'h0000) $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); else pass_cnt++;
    total_cnt++; if (dout !== 32'h0) $display("FAIL reset_dout: got %h expected 00000000", dout); else pass_cnt++;
  endtask

  task automatic test_single_miss();
    @(negedge clk_49m);
    addr[2*AW +: AW] = 16'h1234;
    req = 4'b0100;
    @(negedge clk_49m);
    total_cnt++; if (mem_req !== 1'b1) $display("FAIL miss_mem_req: got %b expected 1", mem_req); else pass_cnt++;
    total_cnt++; if (mem_addr !== 16'h1234) $display("FAIL miss_mem_addr: got %h expected 1234", mem_addr); else pass_cnt++;
    @(negedge clk_49m);
    total_cnt++; if (mem_req !== 1'b1 || ack !== 4'b0000) $display("FAIL miss_hold: got mem_req=%b ack=%b expected 1/0000", mem_req, ack); else pass_cnt++;
    @(negedge clk_49m);
    mem_rdy = 1'b1;
    mem_din = 8'hA5;
    @(negedge clk_49m);
    mem_rdy = 1'b0;
    total_cnt++; if (ack !== 4'b0100) $display("FAIL miss_ack: got %b expected 0100", ack); else pass_cnt++;
    total_cnt++; if (dout[23:16] !== 8'hA5) $display("FAIL miss_dout: got %h expected a5", dout[23:16]); else pass_cnt++;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL miss_mem_req_drop: got %b expected 0", mem_req); else pass_cnt++;
    req = 4'b0000;
    @(negedge clk_49m);
    total_cnt++; if (ack !== 4'b0000 || busy !== 1'b0) $display("FAIL miss_ack_pulse: got ack=%b busy=%b expected 0000/0", ack, busy); else pass_cnt++;
  endtask

  task automatic test_hit();
    @(negedge clk_49m);
    req = 4'b0100;
    @(negedge clk_49m);
    total_cnt++; if (ack !== 4'b0100) $display("FAIL hit_ack: got %b expected 0100", ack); else pass_cnt++;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL hit_mem_req: got %b expected 0", mem_req); else pass_cnt++;
    total_cnt++; if (dout[23:16] !== 8'hA5) $display("FAIL hit_dout: got %h expected a5", dout[23:16]); else pass_cnt++;
    req = 4'b0000;
    @(negedge clk_49m);
    total_cnt++; if (ack !== 4'b0000) $display("FAIL hit_ack_pulse: got %b expected 0000", ack); else pass_cnt++;
  endtask

  task automatic test_inval();
    @(negedge clk_49m);
    inval = 1'b1;
    @(negedge clk_49m);
    inval = 1'b0;
    req = 4'b0100;
    @(negedge clk_49m);
    total_cnt++; if (mem_req !== 1'b1) $display("FAIL inval_refetch: got mem_req=%b expected 1", mem_req); else pass_cnt++;
    inval = 1'b1;
    mem_rdy = 1'b1;
    mem_din = rom(16'h1234);
    @(negedge clk_49m);
    mem_rdy = 1'b0;
    total_cnt++; if (ack !== 4'b0100 || dout[23:16] !== 8'hA5) $display("FAIL inval_fill: got ack=%b dout=%h expected 0100/a5", ack, dout[23:16]); else pass_cnt++;
    req = 4'b0000;
    @(negedge clk_49m);
    inval = 1'b0;
    @(negedge clk_49m);
    req = 4'b0100;
    @(negedge clk_49m);
    total_cnt++; if (mem_req !== 1'b1) $display("FAIL inval_fill_not_cached: got mem_req=%b expected 1", mem_req); else pass_cnt++;
    mem_rdy = 1'b1;
    mem_din = rom(16'h1234);
    @(negedge clk_49m);
    mem_rdy = 1'b0;
    total_cnt++; if (ack !== 4'b0100) $display("FAIL inval_refill_ack: got %b expected 0100", ack); else pass_cnt++;
    req = 4'b0000;
    @(negedge clk_49m);
  endtask

  task automatic test_stray_rdy();
    for (int i = 0; i < 3; i++) begin
      mem_rdy = 1'b1;
      mem_din = 8'h00;
      @(negedge clk_49m);
      total_cnt++; if (ack !== 4'b0000 || dout !== 32'h00A5_0000) $display("FAIL stray_rdy_%0d: got ack=%b dout=%h expected 0000/00a50000", i, ack, dout); else pass_cnt++;
    end
    mem_rdy = 1'b0;
    req = 4'b0100;
    @(negedge clk_49m);
    total_cnt++; if (ack !== 4'b0100 || mem_req !== 1'b0) $display("FAIL stray_valid_kept: got ack=%b mem_req=%b expected 0100/0", ack, mem_req); else pass_cnt++;
    req = 4'b0000;
    @(negedge clk_49m);
  endtask

  task automatic test_contention();
    bit to;
    int exp1 [4] = '{0, 1, 2, 3};
    int exp2 [2] = '{0, 3};
    do_reset();
    g_port.delete(); g_data.delete(); g_maddr.delete();
    for (int p = 0; p < 4; p++) addr[p*AW +: AW] = 16'h4000 + 16'(p * 16'h0111);
    req = 4'b1111;
    run_until_done(200, 3, to);
    total_cnt++; if (to !== 1'b0) $display("FAIL contention_timeout: got timeout expected completion"); else pass_cnt++;
    total_cnt++; if (g_port.size() !== 4) $display("FAIL contention_count: got %0d expected 4", g_port.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < g_port.size(); i++) begin
      total_cnt++; if (g_port[i] !== exp1[i]) $display("FAIL contention_order_%0d: got %0d expected %0d", i, g_port[i], exp1[i]); else pass_cnt++;
      total_cnt++; if (g_data[i] !== rom(16'h4000 + 16'(exp1[i] * 16'h0111))) $display("FAIL contention_data_%0d: got %h expected %h", i, g_data[i], rom(16'h4000 + 16'(exp1[i] * 16'h0111))); else pass_cnt++;
    end
    g_port.delete(); g_data.delete(); g_maddr.delete();
    addr[0 +: AW]    = 16'h5000;
    addr[3*AW +: AW] = 16'h5003;
    req = 4'b1001;
    run_until_done(200, 3, to);
    total_cnt++; if (to !== 1'b0 || g_port.size() !== 2) $display("FAIL wave2_count: got %0d grants timeout=%b expected 2/0", g_port.size(), to); else pass_cnt++;
    for (int i = 0; i < 2 && i < g_port.size(); i++) begin
      total_cnt++; if (g_port[i] !== exp2[i]) $display("FAIL wave2_order_%0d: got %0d expected %0d", i, g_port[i], exp2[i]); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk_49m);
    addr[1*AW +: AW] = 16'hBEEF;
    req = 4'b0010;
    @(negedge clk_49m);
    total_cnt++; if (mem_req !== 1'b1) $display("FAIL midwait_start: got mem_req=%b expected 1", mem_req); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if (mem_req !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0) $display("FAIL midwait_reset: got mem_req=%b ack=%b busy=%b expected 0/0000/0", mem_req, ack, busy); else pass_cnt++;
    @(negedge clk_49m);
    reset = 1'b0;
    req = 4'b0000;
    model_reset();
    @(negedge clk_49m);
    mem_rdy = 1'b1;
    mem_din = 8'h77;
    @(negedge clk_49m);
    mem_rdy = 1'b0;
    total_cnt++; if (ack !== 4'b0000) $display("FAIL midwait_late_rdy: got ack=%b expected 0000", ack); else pass_cnt++;
    @(negedge clk_49m);
    total_cnt++; if (ack !== 4'b0000 || dout !== 32'h0) $display("FAIL midwait_quiet: got ack=%b dout=%h expected 0000/00000000", ack, dout); else pass_cnt++;
  endtask

  task automatic test_random();
    bit            to;
    logic [3:0]    mask, pend;
    logic [AW-1:0] a [4];
    int            exp_port[$];
    logic [AW-1:0] exp_maddr[$];
    int            w;
    do_reset();
    for (int r = 0; r < 40; r++) begin
      g_port.delete(); g_data.delete(); g_maddr.delete();
      exp_port.delete(); exp_maddr.delete();
      mask = 4'($urandom_range(1, 15));
      for (int p = 0; p < 4; p++) begin
        a[p] = 16'h2000 + 16'($urandom_range(0, 2));
        addr[p*AW +: AW] = a[p];
      end
      pend = mask;
      while (pend != 4'b0000) begin
        w = arbitrate(pend, m_ptr);
        m_ptr = w;
        if (!(m_valid[w] && m_tag[w] == a[w])) begin
          exp_maddr.push_back(a[w]);
          m_valid[w] = 1'b1;
          m_tag[w]   = a[w];
        end
        exp_port.push_back(w);
        pend[w] = 1'b0;
      end
      @(negedge clk_49m);
      req = mask;
      run_until_done(300, 3, to);
      total_cnt++; if (to !== 1'b0 || g_port.size() !== exp_port.size()) $display("FAIL rand%0d_grants: got %0d timeout=%b expected %0d", r, g_port.size(), to, exp_port.size()); else pass_cnt++;
      total_cnt++; if (g_maddr.size() !== exp_maddr.size()) $display("FAIL rand%0d_mem_accesses: got %0d expected %0d", r, g_maddr.size(), exp_maddr.size()); else pass_cnt++;
      for (int i = 0; i < exp_port.size() && i < g_port.size(); i++) begin
        total_cnt++; if (g_port[i] !== exp_port[i] || g_data[i] !== rom(a[exp_port[i]])) $display("FAIL rand%0d_grant%0d: got port %0d data %h expected port %0d data %h", r, i, g_port[i], g_data[i], exp_port[i], rom(a[exp_port[i]])); else pass_cnt++;
      end
      for (int i = 0; i < exp_maddr.size() && i < g_maddr.size(); i++) begin
        total_cnt++; if (g_maddr[i] !== exp_maddr[i]) $display("FAIL rand%0d_maddr%0d: got %h expected %h", r, i, g_maddr[i], exp_maddr[i]); else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_hit();
    test_inval();
    test_stray_rdy();
    test_contention();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
